// File: rtl/boss_health.sv
// Boss hit-point tracker: latches missile hits per frame, runs invulnerability and death
// sequences, and gates/recolours the boss pixel stream with a one-clock registered path.
module boss_health #(
    parameter int unsigned MAX_HEALTH    = 8,
    parameter int unsigned INVULN_FRAMES = 16,
    parameter int unsigned DEATH_FRAMES  = 30,
    parameter int unsigned FLASH_PERIOD  = 4,
    parameter logic [7:0]  FLASH_COLOR   = 8'hFF
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       enable,
    input  logic       startOfFrame,
    input  logic       missile_collision,
    input  logic       BossDR,
    input  logic [7:0] BossRGB,
    output logic       outDR,
    output logic [7:0] outRGB,
    output logic [3:0] health,
    output logic       hit_pulse,
    output logic       boss_dead
);

    typedef enum logic [1:0] {
        StAlive,
        StInvuln,
        StDying,
        StDead
    } state_e;

    localparam logic [3:0] HealthInit = 4'(MAX_HEALTH);
    localparam logic [4:0] InvulnLast = 5'(INVULN_FRAMES - 1);
    localparam logic [4:0] DeathLast  = 5'(DEATH_FRAMES - 1);
    localparam logic [4:0] FlashBit   = 5'(FLASH_PERIOD);

    state_e     state_q;
    logic [4:0] frame_cnt_q;
    logic [3:0] health_q;
    logic       hit_latch_q;
    logic       hit_pulse_q;
    logic       boss_dead_q;
    logic       out_dr_q;
    logic [7:0] out_rgb_q;

    logic       hit_now;
    logic       flash_odd;
    logic [3:0] health_dec;

    // A collision on the evaluation clock itself counts toward that frame.
    assign hit_now    = hit_latch_q | missile_collision;
    // FLASH_PERIOD is a power of two, so this bit is the parity of frame_cnt/FLASH_PERIOD.
    assign flash_odd  = |(frame_cnt_q & FlashBit);
    assign health_dec = (health_q == 4'd0) ? 4'd0 : health_q - 4'd1;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= StAlive;
            frame_cnt_q <= 5'd0;
            health_q    <= HealthInit;
            hit_latch_q <= 1'b0;
            hit_pulse_q <= 1'b0;
            boss_dead_q <= 1'b0;
            out_dr_q    <= 1'b0;
            out_rgb_q   <= 8'd0;
        end else begin
            hit_pulse_q <= 1'b0;

            unique case (state_q)
                StAlive: begin
                    out_dr_q  <= BossDR;
                    out_rgb_q <= BossRGB;
                end
                StInvuln: begin
                    out_dr_q  <= BossDR;
                    out_rgb_q <= flash_odd ? BossRGB : FLASH_COLOR;
                end
                StDying: begin
                    out_dr_q  <= flash_odd ? 1'b0 : BossDR;
                    out_rgb_q <= BossRGB;
                end
                StDead: begin
                    out_dr_q  <= 1'b0;
                    out_rgb_q <= 8'd0;
                end
            endcase

            if (enable) begin
                if (startOfFrame) begin
                    hit_latch_q <= 1'b0;
                    unique case (state_q)
                        StAlive: begin
                            if (hit_now) begin
                                health_q    <= health_dec;
                                hit_pulse_q <= 1'b1;
                                frame_cnt_q <= 5'd0;
                                state_q     <= (health_dec == 4'd0) ? StDying : StInvuln;
                            end
                        end
                        StInvuln: begin
                            if (frame_cnt_q == InvulnLast) begin
                                frame_cnt_q <= 5'd0;
                                state_q     <= StAlive;
                            end else begin
                                frame_cnt_q <= frame_cnt_q + 5'd1;
                            end
                        end
                        StDying: begin
                            if (frame_cnt_q == DeathLast) begin
                                frame_cnt_q <= 5'd0;
                                boss_dead_q <= 1'b1;
                                state_q     <= StDead;
                            end else begin
                                frame_cnt_q <= frame_cnt_q + 5'd1;
                            end
                        end
                        StDead: begin
                        end
                    endcase
                end else if (missile_collision) begin
                    hit_latch_q <= 1'b1;
                end
            end
        end
    end

    assign outDR     = out_dr_q;
    assign outRGB    = out_rgb_q;
    assign health    = health_q;
    assign hit_pulse = hit_pulse_q;
    assign boss_dead = boss_dead_q;

endmodule

// File: tb/tb_boss_health.sv
// Randomised bench for boss_health, checked every clock against a frame-count reference model.
module tb_boss_health;

    localparam int MaxHealth    = 8;
    localparam int InvulnFrames = 16;
    localparam int DeathFrames  = 30;
    localparam int FlashPeriod  = 4;
    localparam int FlashColor   = 8'hFF;
    localparam int Big          = 1000;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       enable = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       missile_collision = 1'b0;
    logic       BossDR = 1'b0;
    logic [7:0] BossRGB = 8'd0;
    logic       outDR;
    logic [7:0] outRGB;
    logic [3:0] health;
    logic       hit_pulse;
    logic       boss_dead;

    int checks = 0;
    int errors = 0;
    int pulses_seen = 0;

    // Model: health left, evaluations since the last accepted hit, pending-hit flag.
    int m_health = MaxHealth;
    int m_since  = Big;
    bit m_latch  = 0;

    always #5 clk = ~clk;

    boss_health #(
        .MAX_HEALTH   (MaxHealth),
        .INVULN_FRAMES(InvulnFrames),
        .DEATH_FRAMES (DeathFrames),
        .FLASH_PERIOD (FlashPeriod),
        .FLASH_COLOR  (8'hFF)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .enable           (enable),
        .startOfFrame     (startOfFrame),
        .missile_collision(missile_collision),
        .BossDR           (BossDR),
        .BossRGB          (BossRGB),
        .outDR            (outDR),
        .outRGB           (outRGB),
        .health           (health),
        .hit_pulse        (hit_pulse),
        .boss_dead        (boss_dead)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // 0 alive, 1 invulnerable, 2 dying, 3 dead
    function automatic int model_mode();
        if (m_health > 0) return (m_since >= InvulnFrames) ? 0 : 1;
        return (m_since >= DeathFrames) ? 3 : 2;
    endfunction

    task automatic step(input logic en, input logic sof, input logic coll, input logic rn);
        int   mode;
        bit   even;
        logic exp_dr;
        int   exp_rgb;
        bit   exp_pulse;
        @(negedge clk);
        resetN            = rn;
        enable            = en;
        startOfFrame      = sof;
        missile_collision = coll;
        BossDR            = 1'($urandom);
        BossRGB           = 8'($urandom);

        mode      = model_mode();
        even      = ((m_since / FlashPeriod) % 2) == 0;
        exp_pulse = 0;
        if (!rn) begin
            exp_dr   = 1'b0;
            exp_rgb  = 0;
            m_health = MaxHealth;
            m_since  = Big;
            m_latch  = 0;
        end else begin
            case (mode)
                0: begin exp_dr = BossDR; exp_rgb = BossRGB; end
                1: begin exp_dr = BossDR; exp_rgb = even ? FlashColor : int'(BossRGB); end
                2: begin exp_dr = even ? BossDR : 1'b0; exp_rgb = BossRGB; end
                default: begin exp_dr = 1'b0; exp_rgb = 0; end
            endcase
            if (en) begin
                if (sof) begin
                    if (mode == 0 && (m_latch || coll)) begin
                        m_health  = m_health - 1;
                        m_since   = 0;
                        exp_pulse = 1;
                    end else if (m_since < Big) begin
                        m_since = m_since + 1;
                    end
                    m_latch = 0;
                end else if (coll) begin
                    m_latch = 1;
                end
            end
        end

        @(posedge clk);
        #1;
        if (hit_pulse === 1'b1) pulses_seen++;
        check_eq("outDR", 32'(outDR), 32'(exp_dr));
        check_eq("outRGB", 32'(outRGB), 32'(exp_rgb));
        check_eq("health", 32'(health), 32'(m_health));
        check_eq("hit_pulse", 32'(hit_pulse), 32'(exp_pulse));
        check_eq("boss_dead", 32'(boss_dead), 32'(model_mode() == 3));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Frame of len clocks; collision on every pixel clock with probability pct percent.
    task automatic frame(input int len, input int pct, input logic en);
        for (int i = 0; i < len - 1; i++) step(en, 1'b0, 1'($urandom_range(99) < pct), 1'b1);
        step(en, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic kill_boss();
        for (int h = 0; h < MaxHealth; h++) begin
            frame(4, 100, 1'b1);
            for (int f = 0; f < 19; f++) frame(4, 0, 1'b1);
        end
    endtask

    initial begin
        do_reset();
        do_reset();
        check_eq("rst_health", 32'(health), 32'(MaxHealth));
        check_eq("rst_dead", 32'(boss_dead), 0);

        // Many collision clocks in one frame give a single hit.
        pulses_seen = 0;
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check_eq("burst_health", 32'(health), 7);
        check_eq("burst_pulses", 32'(pulses_seen), 1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("burst_flash", 32'(outRGB), 32'(FlashColor));

        // Collision on the evaluation clock counts.
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("same_clk_health", 32'(health), 7);

        // A hit every frame for 20 frames: hits at frame 1 and 18 only.
        do_reset();
        pulses_seen = 0;
        for (int f = 0; f < 20; f++) frame(5, 100, 1'b1);
        check_eq("every_frame_health", 32'(health), 6);
        check_eq("every_frame_pulses", 32'(pulses_seen), 2);

        // Disabled: collisions and frame pulses have no effect.
        for (int i = 0; i < 40; i++) step(1'b0, 1'($urandom), 1'($urandom), 1'b1);
        check_eq("frozen_health", 32'(health), 6);

        // Full defeat, then 11 more frames to complete the 30-frame death sequence.
        do_reset();
        kill_boss();
        check_eq("dying_health", 32'(health), 0);
        check_eq("dying_not_dead", 32'(boss_dead), 0);
        for (int f = 0; f < 11; f++) frame(4, 50, 1'b1);
        check_eq("dead_flag", 32'(boss_dead), 1);

        // Reset during the death sequence.
        do_reset();
        kill_boss();
        do_reset();
        check_eq("mid_dying_rst_health", 32'(health), 32'(MaxHealth));
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check_eq("mid_dying_rst_dr", 32'(outDR), 32'(BossDR));
        check_eq("mid_dying_rst_dead", 32'(boss_dead), 0);

        // Random frames with occasional disable and reset.
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(99) < 2) do_reset();
            frame(int'($urandom_range(2, 6)), 30, 1'($urandom_range(99) < 90));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
